aurora_link_controller: RTL and testbench
=========================================

// Module: aurora_link_controller
// PURPOSE
//  Brings up and supervises one 4-lane Aurora core. Sequences pma_init/reset_pb, waits for a stable
//  channel, and flags link_ready to the user datapath. Re-runs bring-up on timeout or link loss, and
//  counts retries and recoveries. Sits beside the flow monitor and takes the same 13-bit aurora_status.
// PARAMETERS
//  PMA_INIT_CYCLES    256      cycles pma_init is held high in PMA_INIT
//  RESET_PB_CYCLES    128      extra cycles reset_pb is held after pma_init drops
//  UP_TIMEOUT_CYCLES  1048576  max cycles spent in WAIT_UP+STABLE before a retry
//  STABLE_CYCLES      1024     consecutive cycles channel-good required before link_ready
//  MAX_RETRIES        8        consecutive failed attempts before FAILED (AURORA_RETRY_LIMIT_EN only)
// PORTS
//  clk           in   1   single clock; all logic synchronous to it
//  rst           in   1   asynchronous, active-high reset
//  enable        in   1   1 = run bring-up/supervision; 0 = hold core in reset
//  aurora_status in   13  [3:0] gt_powergood, [7:4] line_up, [8] pll_lock, [9] mmcm_not_locked,
//                         [10] hard_err, [11] soft_err, [12] channel_up
//  pma_init      out  1   to core pma_init
//  reset_pb      out  1   to core reset_pb
//  link_ready    out  1   channel stable; user TX/RX may run
//  state         out  3   current FSM state (encoding below)
//  retry_count   out  32  bring-up timeouts since reset, saturating
//  recovery_count out 32  losses of an established link since reset, saturating
//  link_failed   out  1   retry limit hit (constant 0 without AURORA_RETRY_LIMIT_EN)
// BEHAVIOUR
//  Reset (async): state=IDLE, pma_init=1, reset_pb=1, link_ready=0, counters=0, link_failed=0.
//  All outputs registered. good = status[12] & status[8] & ~status[9] & ~status[10]. soft_err ignored.
//  States: IDLE=0 PMA_INIT=1 RESET_PB=2 WAIT_UP=3 STABLE=4 UP=5 FAILED=6.
//  - IDLE: pma_init=1, reset_pb=1. enable=1 -> PMA_INIT, timer cleared.
//  - PMA_INIT: pma_init=1, reset_pb=1 for exactly PMA_INIT_CYCLES cycles -> RESET_PB.
//  - RESET_PB: pma_init=0, reset_pb=1 for exactly RESET_PB_CYCLES cycles -> WAIT_UP; up-timer cleared.
//  - WAIT_UP: both low. good -> STABLE, stable-timer cleared. Up-timer reaches UP_TIMEOUT_CYCLES
//    -> retry_count+1 and PMA_INIT. If good and timeout coincide, good wins.
//  - STABLE: good held for STABLE_CYCLES consecutive cycles -> UP. good drops -> WAIT_UP.
//    Up-timer keeps running across WAIT_UP/STABLE. Timeout here -> retry as in WAIT_UP.
//  - UP: link_ready=1 (registered, set on the same edge that enters UP). Consecutive-failure count cleared.
//    ~good for 1 cycle -> recovery_count+1, link_ready=0, PMA_INIT.
//  - enable=0 in any state -> IDLE next cycle, link_ready=0. This has priority over all other transitions.
//  - Counters saturate at 32'hFFFF_FFFF. Never wrap. Timer widths are $clog2 of the largest parameter + 1.
//  - link_ready is 1 only in UP.
//  - Status inputs are already synchronous to clk.
// CONFIGURATION
//  AURORA_RETRY_LIMIT_EN defined:
//    - A consecutive-failure counter increments on each timeout and clears on entering UP.
//    - When it reaches MAX_RETRIES, go to FAILED instead of PMA_INIT.
//    - FAILED: pma_init=1, reset_pb=1, link_failed=1. Only enable=0 (-> IDLE, link_failed=0) exits.
//  Not defined: retries indefinitely, FAILED unreachable, link_failed tied 0.
// TESTING
//  (params: PMA_INIT=4, RESET_PB=4, UP_TIMEOUT=64, STABLE=8, MAX_RETRIES=2)
//  1 enable=1, status=0x11FF from cycle 0 -> pma_init low at cycle 5, reset_pb low at 9.
//    link_ready=1 after a further 9 cycles (1 WAIT_UP + 8 STABLE).
//  2 status=0x01FF always -> retry_count increments every 72 cycles (8 reset + 64 wait).
//    pma_init re-pulses each time. link_ready stays 0.
//  3 In UP, clear bit 12 for 1 cycle -> recovery_count=1, link_ready=0 next edge.
//    Full re-sequence, then link_ready=1 again.
//  4 In STABLE, glitch good low at stable cycle 5 -> back to WAIT_UP, no retry_count change.
//    UP is reached 8 good cycles later.
//  5 AURORA_RETRY_LIMIT_EN, status never good -> state=6, link_failed=1 after 2 timeouts.
//    enable=0 -> IDLE, link_failed=0.
//  6 Assert rst mid-STABLE -> all outputs at reset values immediately (async), counters=0.

Source files
------------

// File: rtl/aurora_link_controller.sv
// Bring-up and supervision FSM for one 4-lane Aurora core: sequences pma_init/reset_pb,
// qualifies the channel, and retries or recovers. Optional retry limit: AURORA_RETRY_LIMIT_EN.
module aurora_link_controller #(
  parameter int unsigned PMA_INIT_CYCLES   = 256,
  parameter int unsigned RESET_PB_CYCLES   = 128,
  parameter int unsigned UP_TIMEOUT_CYCLES = 1048576,
  parameter int unsigned STABLE_CYCLES     = 1024,
  parameter int unsigned MAX_RETRIES       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [12:0] aurora_status,
  output logic        pma_init,
  output logic        reset_pb,
  output logic        link_ready,
  output logic [2:0]  state,
  output logic [31:0] retry_count,
  output logic [31:0] recovery_count,
  output logic        link_failed
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PMA_INIT = 3'd1;
  localparam logic [2:0] ST_RESET_PB = 3'd2;
  localparam logic [2:0] ST_WAIT_UP  = 3'd3;
  localparam logic [2:0] ST_STABLE   = 3'd4;
  localparam logic [2:0] ST_UP       = 3'd5;
  localparam logic [2:0] ST_FAILED   = 3'd6;

  localparam int unsigned MAX_A = (PMA_INIT_CYCLES > RESET_PB_CYCLES) ? PMA_INIT_CYCLES : RESET_PB_CYCLES;
  localparam int unsigned MAX_B = (UP_TIMEOUT_CYCLES > STABLE_CYCLES) ? UP_TIMEOUT_CYCLES : STABLE_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW    = $clog2(MAX_P) + 1;
  localparam int unsigned FW    = $clog2(MAX_RETRIES + 1) + 1;

  localparam logic [TW-1:0] PMA_LAST    = TW'(PMA_INIT_CYCLES - 1);
  localparam logic [TW-1:0] RPB_LAST    = TW'(RESET_PB_CYCLES - 1);
  localparam logic [TW-1:0] UP_LAST     = TW'(UP_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX    = FW'(MAX_RETRIES);
  localparam logic [FW-1:0] FAIL_LAST   = FW'(MAX_RETRIES - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] up_timer_q, up_timer_d;
  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic [31:0]   retry_count_q, retry_count_d;
  logic [31:0]   recovery_count_q, recovery_count_d;
  logic          pma_init_q, pma_init_d;
  logic          reset_pb_q, reset_pb_d;
  logic          link_ready_q, link_ready_d;
  logic          link_failed_q, link_failed_d;

  logic good;
  logic timeout;
  logic retry_limit_hit;
  logic unused_status;

  assign good    = aurora_status[12] & aurora_status[8] & ~aurora_status[9] & ~aurora_status[10];
  assign timeout = (up_timer_q >= UP_LAST);
  assign unused_status = ^{aurora_status[11], aurora_status[7:0]};

`ifdef AURORA_RETRY_LIMIT_EN
  assign retry_limit_hit = (fail_cnt_q >= FAIL_LAST);
`else
  assign retry_limit_hit = 1'b0;
`endif

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d          = state_q;
    timer_d          = '0;
    up_timer_d       = up_timer_q;
    fail_cnt_d       = fail_cnt_q;
    retry_count_d    = retry_count_q;
    recovery_count_d = recovery_count_q;

    if (!enable) begin
      // Disable overrides every transition; a new session starts with a clean failure streak.
      state_d    = ST_IDLE;
      fail_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_PMA_INIT;

        ST_PMA_INIT: begin
          if (timer_q == PMA_LAST) state_d = ST_RESET_PB;
          else                     timer_d = timer_q + 1'b1;
        end

        ST_RESET_PB: begin
          if (timer_q == RPB_LAST) begin
            state_d    = ST_WAIT_UP;
            up_timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        ST_WAIT_UP, ST_STABLE: begin
          up_timer_d = up_timer_q + 1'b1;
          if (state_q == ST_WAIT_UP && good) begin
            state_d = ST_STABLE;
          end else if (state_q == ST_STABLE && good && timer_q == STABLE_LAST) begin
            state_d    = ST_UP;
            fail_cnt_d = '0;
          end else if (timeout) begin
            // Timeout beats a good-drop in STABLE so the up-timer can never run past its limit.
            retry_count_d = sat_inc(retry_count_q);
            fail_cnt_d    = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + 1'b1;
            state_d       = retry_limit_hit ? ST_FAILED : ST_PMA_INIT;
          end else if (state_q == ST_STABLE && !good) begin
            state_d = ST_WAIT_UP;
          end else if (state_q == ST_STABLE) begin
            timer_d = timer_q + 1'b1;
          end
        end

        ST_UP: begin
          if (!good) begin
            recovery_count_d = sat_inc(recovery_count_q);
            state_d          = ST_PMA_INIT;
          end
        end

        ST_FAILED: state_d = ST_FAILED;

        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered versions of what the next state demands.
    pma_init_d   = (state_d == ST_IDLE) || (state_d == ST_PMA_INIT) || (state_d == ST_FAILED);
    reset_pb_d   = pma_init_d || (state_d == ST_RESET_PB);
    link_ready_d = (state_d == ST_UP);
`ifdef AURORA_RETRY_LIMIT_EN
    link_failed_d = (state_d == ST_FAILED);
`else
    link_failed_d = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      timer_q          <= '0;
      up_timer_q       <= '0;
      fail_cnt_q       <= '0;
      retry_count_q    <= '0;
      recovery_count_q <= '0;
      pma_init_q       <= 1'b1;
      reset_pb_q       <= 1'b1;
      link_ready_q     <= 1'b0;
      link_failed_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      up_timer_q       <= up_timer_d;
      fail_cnt_q       <= fail_cnt_d;
      retry_count_q    <= retry_count_d;
      recovery_count_q <= recovery_count_d;
      pma_init_q       <= pma_init_d;
      reset_pb_q       <= reset_pb_d;
      link_ready_q     <= link_ready_d;
      link_failed_q    <= link_failed_d;
    end
  end

  assign state          = state_q;
  assign pma_init       = pma_init_q;
  assign reset_pb       = reset_pb_q;
  assign link_ready     = link_ready_q;
  assign link_failed    = link_failed_q;
  assign retry_count    = retry_count_q;
  assign recovery_count = recovery_count_q;

endmodule

// File: tb/tb_aurora_link_controller.sv
// Directed bench for aurora_link_controller with small timing parameters; covers bring-up,
// retry, recovery, STABLE glitch, retry limit (AURORA_RETRY_LIMIT_EN) and async reset.
module tb_aurora_link_controller;

  localparam logic [12:0] S_GOOD = 13'h11FF;
  localparam logic [12:0] S_DOWN = 13'h01FF;
`ifdef AURORA_RETRY_LIMIT_EN
  localparam logic RLIM = 1'b1;
`else
  localparam logic RLIM = 1'b0;
`endif

  logic        clk, rst, enable;
  logic [12:0] aurora_status;
  logic        pma_init, reset_pb, link_ready, link_failed;
  logic [2:0]  state;
  logic [31:0] retry_count, recovery_count;

  int total = 0;
  int bad   = 0;

  aurora_link_controller #(
    .PMA_INIT_CYCLES(4), .RESET_PB_CYCLES(4), .UP_TIMEOUT_CYCLES(64),
    .STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .aurora_status(aurora_status),
    .pma_init(pma_init), .reset_pb(reset_pb), .link_ready(link_ready),
    .state(state), .retry_count(retry_count), .recovery_count(recovery_count),
    .link_failed(link_failed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [12:0] status;
    int          adv;
    logic [2:0]  st;
    logic        pma;
    logic        rpb;
    logic        lr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    aurora_status = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic lr_seen;
    // Edge counts from the first edge after reset release; the table advances then checks.
    vecs[0] = '{1'b0, S_GOOD, 0, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, S_GOOD, 1, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, S_GOOD, 3, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, S_GOOD, 1, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, S_GOOD, 3, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, S_GOOD, 1, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, S_GOOD, 1, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, S_GOOD, 7, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, S_GOOD, 1, 3'd5, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, S_GOOD, 1, 3'd0, 1'b1, 1'b1, 1'b0};

    // Clean bring-up: pma_init low at edge 5, reset_pb low at 9, link_ready at 18.
    do_reset();
    check("rst_retry", retry_count, 32'd0);
    check("rst_recovery", recovery_count, 32'd0);
    check("rst_failed", {31'd0, link_failed}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      enable = vecs[i].en;
      aurora_status = vecs[i].status;
      tick(vecs[i].adv);
      check($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, vecs[i].st});
      check($sformatf("vec%0d_pma", i), {31'd0, pma_init}, {31'd0, vecs[i].pma});
      check($sformatf("vec%0d_rpb", i), {31'd0, reset_pb}, {31'd0, vecs[i].rpb});
      check($sformatf("vec%0d_lr", i), {31'd0, link_ready}, {31'd0, vecs[i].lr});
    end

    // Link loss in UP, full re-sequence, then async reset mid-STABLE.
    do_reset();
    enable = 1'b1;
    aurora_status = S_GOOD;
    tick(18);
    check("rec_up_state", {29'd0, state}, 32'd5);
    check("rec_up_lr", {31'd0, link_ready}, 32'd1);
    aurora_status = S_DOWN;
    tick(1);
    check("rec_loss_state", {29'd0, state}, 32'd1);
    check("rec_loss_lr", {31'd0, link_ready}, 32'd0);
    check("rec_loss_count", recovery_count, 32'd1);
    check("rec_loss_pma", {31'd0, pma_init}, 32'd1);
    aurora_status = S_GOOD;
    tick(16);
    check("rec_pre_state", {29'd0, state}, 32'd4);
    check("rec_pre_lr", {31'd0, link_ready}, 32'd0);
    tick(1);
    check("rec_again_state", {29'd0, state}, 32'd5);
    check("rec_again_lr", {31'd0, link_ready}, 32'd1);
    check("rec_again_retry", retry_count, 32'd0);
    aurora_status = S_DOWN;
    tick(1);
    check("rec_second_count", recovery_count, 32'd2);
    aurora_status = S_GOOD;
    tick(9);
    check("ar_pre_state", {29'd0, state}, 32'd4);
    #2 rst = 1'b1;
    #1;
    check("ar_state", {29'd0, state}, 32'd0);
    check("ar_pma", {31'd0, pma_init}, 32'd1);
    check("ar_rpb", {31'd0, reset_pb}, 32'd1);
    check("ar_lr", {31'd0, link_ready}, 32'd0);
    check("ar_recovery", recovery_count, 32'd0);
    check("ar_retry", retry_count, 32'd0);
    check("ar_failed", {31'd0, link_failed}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Good glitch in the 5th STABLE cycle: back to WAIT_UP, then 1 WAIT_UP + 8 STABLE to UP.
    do_reset();
    enable = 1'b1;
    aurora_status = S_GOOD;
    tick(14);
    check("gl_stable_state", {29'd0, state}, 32'd4);
    aurora_status = S_DOWN;
    tick(1);
    check("gl_wait_state", {29'd0, state}, 32'd3);
    aurora_status = S_GOOD;
    tick(1);
    check("gl_restable_state", {29'd0, state}, 32'd4);
    tick(7);
    check("gl_pre_lr", {31'd0, link_ready}, 32'd0);
    tick(1);
    check("gl_up_state", {29'd0, state}, 32'd5);
    check("gl_up_lr", {31'd0, link_ready}, 32'd1);
    check("gl_retry", retry_count, 32'd0);

    // Never good: retry every 72 edges; second timeout hits the limit when enabled.
    do_reset();
    enable = 1'b1;
    aurora_status = S_DOWN;
    lr_seen = 1'b0;
    for (int i = 0; i < 72; i++) begin
      tick(1);
      lr_seen = lr_seen | link_ready;
    end
    check("to_wait_state", {29'd0, state}, 32'd3);
    check("to_wait_retry", retry_count, 32'd0);
    tick(1);
    check("to1_state", {29'd0, state}, 32'd1);
    check("to1_retry", retry_count, 32'd1);
    check("to1_pma", {31'd0, pma_init}, 32'd1);
    tick(4);
    check("to1_pma_low", {31'd0, pma_init}, 32'd0);
    check("to1_rpb_state", {29'd0, state}, 32'd2);
    for (int i = 0; i < 68; i++) begin
      tick(1);
      lr_seen = lr_seen | link_ready;
    end
    check("to_lr_never", {31'd0, lr_seen}, 32'd0);
    check("to2_retry", retry_count, 32'd2);
    check("to2_state", {29'd0, state}, RLIM ? 32'd6 : 32'd1);
    check("to2_failed", {31'd0, link_failed}, {31'd0, RLIM});
    check("to2_pma", {31'd0, pma_init}, 32'd1);
    enable = 1'b0;
    tick(1);
    check("dis_state", {29'd0, state}, 32'd0);
    check("dis_failed", {31'd0, link_failed}, 32'd0);
    check("dis_retry", retry_count, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
